// File: rtl/muldiv_seq_ctrl.sv
// rtl/muldiv_seq_ctrl.sv - sequencing controller for the multi-cycle multiply/divide unit
// Optional feature macro: MULDIV_EARLY_OUT_EN (divide-by-zero skips the DIV state)

module muldiv_seq_ctrl #(
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 32,
    parameter int CNT_W   = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ismultE,
    input  logic             isdivE,
    input  logic             signedE,
    input  logic             cancel,
    input  logic             hold,
    input  logic             divzero,
    output logic             stall_req,
    output logic             busy,
    output logic             mul_go,
    output logic             div_go,
    output logic             signed_o,
    output logic             result_valid,
    output logic             hiwrite,
    output logic             lowrite,
    output logic [CNT_W-1:0] cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } stateT;

    // Counter load values: the op spends LAT cycles in MUL/DIV, exiting when cnt reaches 0
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    stateT state;
    logic  accept;
    logic  earlyOut;

    // Accept is gated by rst so every output reads 0 while reset is asserted
    assign accept = rst && (state == IDLE) && (ismultE || isdivE) && !cancel;

`ifdef MULDIV_EARLY_OUT_EN
    // A divide by zero has no meaningful result; commit straight away
    assign earlyOut = accept && isdivE && divzero;
`else
    logic unusedDivzero;
    assign unusedDivzero = divzero;
    assign earlyOut      = 1'b0;
`endif

    // State, remaining-cycle counter and latched signed flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            signed_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        signed_o <= signedE;
                        if (earlyOut) begin
                            state <= DONE;
                            cnt   <= '0;
                        end else if (isdivE) begin
                            state <= DIV;
                            cnt   <= DIV_LOAD;
                        end else begin
                            state <= MUL;
                            cnt   <= MUL_LOAD;
                        end
                    end
                end
                MUL, DIV: begin
                    if (cancel) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == '0) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                DONE: begin
                    // The op has committed: cancel is ignored, only hold delays the write
                    if (!hold) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Start pulses exist only in the accept cycle, so they are decoded from accept directly
    assign mul_go       = accept && !isdivE;
    assign div_go       = accept && isdivE && !earlyOut;
    assign busy         = (state == MUL) || (state == DIV);
    assign stall_req    = accept || busy;
    assign result_valid = (state == DONE);
    assign hiwrite      = (state == DONE) && !hold;
    assign lowrite      = (state == DONE) && !hold;

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// tb/tb_muldiv_seq_ctrl.sv - self-checking bench for muldiv_seq_ctrl

module tb_muldiv_seq_ctrl;

    logic       clk, rst, ismultE, isdivE, signedE, cancel, hold, divzero;
    logic       stall_req, busy, mul_go, div_go, signed_o, result_valid, hiwrite, lowrite;
    logic [5:0] cnt;
    logic       stall1, busy1, mulGo1, divGo1, signed1, rv1, hi1, lo1;
    logic [5:0] cnt1;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        int   cyc;
        logic sgn;
    } expT;
    expT expQ[$];

    logic [63:0] stallV, hiV, loV, rvV, busyV, mgoV, dgoV, sgnV, stall1V, hi1V;
    int          cntV[64];
    int          cnt1V[64];

    muldiv_seq_ctrl #(.MUL_LAT(2), .DIV_LAT(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .ismultE(ismultE), .isdivE(isdivE), .signedE(signedE),
        .cancel(cancel), .hold(hold), .divzero(divzero), .stall_req(stall_req),
        .busy(busy), .mul_go(mul_go), .div_go(div_go), .signed_o(signed_o),
        .result_valid(result_valid), .hiwrite(hiwrite), .lowrite(lowrite), .cnt(cnt)
    );

    muldiv_seq_ctrl #(.MUL_LAT(1), .DIV_LAT(1), .CNT_W(6)) dut1 (
        .clk(clk), .rst(rst), .ismultE(ismultE), .isdivE(isdivE), .signedE(signedE),
        .cancel(cancel), .hold(hold), .divzero(divzero), .stall_req(stall1),
        .busy(busy1), .mul_go(mulGo1), .div_go(divGo1), .signed_o(signed1),
        .result_valid(rv1), .hiwrite(hi1), .lowrite(lo1), .cnt(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one issue at cycle 0 (plus an optional extra mult) and records outputs per cycle
    task automatic runCycles(input int n, input bit m, input bit d, input bit s, input bit dz,
                             input int cancelAt, input int holdFrom, input int holdLen,
                             input int multAt);
        stallV = '0; hiV = '0; loV = '0; rvV = '0; busyV = '0;
        mgoV = '0; dgoV = '0; sgnV = '0; stall1V = '0; hi1V = '0;
        for (int c = 0; c < n; c++) begin
            ismultE = (c == 0 && m) || (c == multAt);
            isdivE  = (c == 0 && d);
            signedE = (c == 0 && s);
            divzero = (c == 0 && dz);
            cancel  = (c == cancelAt);
            hold    = (c >= holdFrom) && (c < holdFrom + holdLen);
            @(negedge clk);
            stallV[c] = stall_req; hiV[c] = hiwrite; loV[c] = lowrite; rvV[c] = result_valid;
            busyV[c] = busy; mgoV[c] = mul_go; dgoV[c] = div_go; sgnV[c] = signed_o;
            stall1V[c] = stall1; hi1V[c] = hi1;
            cntV[c] = int'(cnt); cnt1V[c] = int'(cnt1);
            @(posedge clk);
            #1;
        end
        ismultE = 0; isdivE = 0; signedE = 0; divzero = 0; cancel = 0; hold = 0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({stall_req, busy, mul_go, div_go, signed_o, result_valid, hiwrite, lowrite} !== 8'h00) begin
            fails++;
            $display("FAIL reset_outputs: got %b expected 00000000",
                     {stall_req, busy, mul_go, div_go, signed_o, result_valid, hiwrite, lowrite});
        end
        checks++;
        if (cnt !== 6'd0) begin
            fails++;
            $display("FAIL reset_cnt: got %0d expected 0", cnt);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_basic_mult();
        expQ.push_back('{cyc: 3, sgn: 1'b0});
        runCycles(6, 1, 0, 0, 0, -1, -1, 0, -1);
        checks++;
        if (stallV !== 64'h7) begin fails++; $display("FAIL mult_stall: got %h expected 7", stallV); end
        checks++;
        if (mgoV !== 64'h1 || dgoV !== 64'h0) begin
            fails++; $display("FAIL mult_go: got mul %h div %h expected mul 1 div 0", mgoV, dgoV);
        end
        checks++;
        if (hiV !== 64'h8 || loV !== 64'h8) begin
            fails++; $display("FAIL mult_strobes: got hi %h lo %h expected 8", hiV, loV);
        end
        checks++;
        if (rvV !== 64'h8) begin fails++; $display("FAIL mult_valid: got %h expected 8", rvV); end
        checks++;
        if (cntV[1] != 1 || cntV[2] != 0) begin
            fails++; $display("FAIL mult_cnt: got %0d,%0d expected 1,0", cntV[1], cntV[2]);
        end
        while (expQ.size() > 0) begin
            expT e = expQ.pop_front();
            checks++;
            if (hiV[e.cyc] !== 1'b1 || sgnV[e.cyc] !== e.sgn) begin
                fails++; $display("FAIL mult_sb: got hi %b sgn %b at %0d expected 1 %b",
                                  hiV[e.cyc], sgnV[e.cyc], e.cyc, e.sgn);
            end
        end
        // Latency-1 instance saw the same issue
        checks++;
        if (stall1V !== 64'h3 || hi1V !== 64'h4) begin
            fails++; $display("FAIL lat1_timing: got stall %h hi %h expected 3 4", stall1V, hi1V);
        end
        checks++;
        if (cnt1V[1] != 0) begin fails++; $display("FAIL lat1_cnt: got %0d expected 0", cnt1V[1]); end
    endtask

    task automatic test_hold();
        expQ.push_back('{cyc: 6, sgn: 1'b0});
        runCycles(9, 1, 0, 0, 0, -1, 3, 3, -1);
        checks++;
        if (rvV !== 64'h78) begin fails++; $display("FAIL hold_valid: got %h expected 78", rvV); end
        checks++;
        if (hiV !== 64'h40 || loV !== 64'h40) begin
            fails++; $display("FAIL hold_strobes: got hi %h lo %h expected 40", hiV, loV);
        end
        while (expQ.size() > 0) begin
            expT e = expQ.pop_front();
            checks++;
            if (hiV[e.cyc] !== 1'b1) begin
                fails++; $display("FAIL hold_sb: got %b at %0d expected 1", hiV[e.cyc], e.cyc);
            end
        end
    endtask

    task automatic test_signed_div();
        expQ.push_back('{cyc: 33, sgn: 1'b1});
        runCycles(36, 0, 1, 1, 0, -1, -1, 0, -1);
        checks++;
        if (stallV !== 64'h1_FFFF_FFFF) begin
            fails++; $display("FAIL div_stall: got %h expected 1ffffffff", stallV);
        end
        checks++;
        if (sgnV[0] !== 1'b0 || sgnV[1] !== 1'b1) begin
            fails++; $display("FAIL div_signed: got %b,%b expected 0,1", sgnV[0], sgnV[1]);
        end
        checks++;
        if (dgoV !== 64'h1 || mgoV !== 64'h0) begin
            fails++; $display("FAIL div_go: got div %h mul %h expected 1 0", dgoV, mgoV);
        end
        checks++;
        if ($countones(hiV) != 1) begin
            fails++; $display("FAIL div_strobe_count: got %0d expected 1", $countones(hiV));
        end
        while (expQ.size() > 0) begin
            expT e = expQ.pop_front();
            checks++;
            if (hiV[e.cyc] !== 1'b1 || sgnV[e.cyc] !== e.sgn) begin
                fails++; $display("FAIL div_sb: got hi %b sgn %b at %0d expected 1 %b",
                                  hiV[e.cyc], sgnV[e.cyc], e.cyc, e.sgn);
            end
        end
    endtask

    task automatic test_reset_midop();
        int hiCount = 0;
        ismultE = 1; signedE = 1;
        @(negedge clk);
        @(posedge clk);
        #1;
        ismultE = 0; signedE = 0;
        rst = 1'b0;
        #1;
        checks++;
        if ({busy, stall_req, hiwrite, lowrite, result_valid} !== 5'b0) begin
            fails++; $display("FAIL midop_reset: got %b expected 00000",
                              {busy, stall_req, hiwrite, lowrite, result_valid});
        end
        checks++;
        if (cnt !== 6'd0 || signed_o !== 1'b0) begin
            fails++; $display("FAIL midop_regs: got cnt %0d sgn %b expected 0 0", cnt, signed_o);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (hiwrite === 1'b1 || lowrite === 1'b1) hiCount++;
        end
        checks++;
        if (hiCount != 0) begin fails++; $display("FAIL midop_nowrite: got %0d expected 0", hiCount); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_cancel();
        expQ.push_back('{cyc: 14, sgn: 1'b0});
        runCycles(20, 0, 1, 0, 0, 10, -1, 0, 11);
        checks++;
        if (busyV[11] !== 1'b0 || stallV[11] !== 1'b1 || mgoV[11] !== 1'b1) begin
            fails++; $display("FAIL cancel_reaccept: got busy %b stall %b go %b expected 0 1 1",
                              busyV[11], stallV[11], mgoV[11]);
        end
        checks++;
        if (cntV[11] != 0) begin fails++; $display("FAIL cancel_cnt: got %0d expected 0", cntV[11]); end
        checks++;
        if (stallV !== 64'h3FFF) begin fails++; $display("FAIL cancel_stall: got %h expected 3fff", stallV); end
        checks++;
        if ($countones(hiV) != 1) begin
            fails++; $display("FAIL cancel_strobes: got %0d expected 1", $countones(hiV));
        end
        while (expQ.size() > 0) begin
            expT e = expQ.pop_front();
            checks++;
            if (hiV[e.cyc] !== 1'b1) begin
                fails++; $display("FAIL cancel_sb: got %b at %0d expected 1", hiV[e.cyc], e.cyc);
            end
        end
        // Cancel while idle blocks acceptance
        runCycles(4, 1, 0, 0, 0, 0, -1, 0, -1);
        checks++;
        if (stallV !== 64'h0 || mgoV !== 64'h0 || hiV !== 64'h0) begin
            fails++; $display("FAIL cancel_idle: got stall %h go %h hi %h expected 0", stallV, mgoV, hiV);
        end
    endtask

    task automatic test_priority();
        expQ.push_back('{cyc: 33, sgn: 1'b0});
        runCycles(36, 1, 1, 0, 0, -1, -1, 0, -1);
        checks++;
        if (mgoV !== 64'h0 || dgoV !== 64'h1) begin
            fails++; $display("FAIL prio_go: got mul %h div %h expected 0 1", mgoV, dgoV);
        end
        while (expQ.size() > 0) begin
            expT e = expQ.pop_front();
            checks++;
            if (hiV !== (64'h1 << e.cyc)) begin
                fails++; $display("FAIL prio_sb: got %h expected strobe at %0d", hiV, e.cyc);
            end
        end
    endtask

    task automatic test_back_to_back();
        // Issue during DONE is ignored
        expQ.push_back('{cyc: 3, sgn: 1'b0});
        runCycles(8, 1, 0, 0, 0, -1, -1, 0, 3);
        checks++;
        if (mgoV !== 64'h1) begin fails++; $display("FAIL b2b_done_ignore: got %h expected 1", mgoV); end
        while (expQ.size() > 0) begin
            expT e = expQ.pop_front();
            checks++;
            if (hiV !== (64'h1 << e.cyc)) begin
                fails++; $display("FAIL b2b_sb1: got %h expected strobe at %0d", hiV, e.cyc);
            end
        end
        // Issue in the IDLE cycle right after DONE is accepted
        expQ.push_back('{cyc: 3, sgn: 1'b0});
        expQ.push_back('{cyc: 7, sgn: 1'b0});
        runCycles(10, 1, 0, 0, 0, -1, -1, 0, 4);
        checks++;
        if (mgoV !== 64'h11) begin fails++; $display("FAIL b2b_go: got %h expected 11", mgoV); end
        checks++;
        if ($countones(hiV) != 2) begin
            fails++; $display("FAIL b2b_count: got %0d expected 2", $countones(hiV));
        end
        while (expQ.size() > 0) begin
            expT e = expQ.pop_front();
            checks++;
            if (hiV[e.cyc] !== 1'b1) begin
                fails++; $display("FAIL b2b_sb2: got %b at %0d expected 1", hiV[e.cyc], e.cyc);
            end
        end
    endtask

    task automatic test_early_out();
`ifdef MULDIV_EARLY_OUT_EN
        expQ.push_back('{cyc: 1, sgn: 1'b0});
`else
        expQ.push_back('{cyc: 33, sgn: 1'b0});
`endif
        runCycles(36, 0, 1, 0, 1, -1, -1, 0, -1);
        checks++;
`ifdef MULDIV_EARLY_OUT_EN
        if (dgoV !== 64'h0 || stallV !== 64'h1) begin
            fails++; $display("FAIL early_go: got div %h stall %h expected 0 1", dgoV, stallV);
        end
`else
        if (dgoV !== 64'h1 || stallV !== 64'h1_FFFF_FFFF) begin
            fails++; $display("FAIL early_go: got div %h stall %h expected 1 1ffffffff", dgoV, stallV);
        end
`endif
        while (expQ.size() > 0) begin
            expT e = expQ.pop_front();
            checks++;
            if (hiV !== (64'h1 << e.cyc)) begin
                fails++; $display("FAIL early_sb: got %h expected strobe at %0d", hiV, e.cyc);
            end
        end
    endtask

    initial begin
        rst = 1'b0; ismultE = 0; isdivE = 0; signedE = 0; cancel = 0; hold = 0; divzero = 0;
        test_reset();
        test_basic_mult();
        test_hold();
        test_signed_div();
        test_reset_midop();
        test_cancel();
        test_priority();
        test_back_to_back();
        test_early_out();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/muldiv_seq_ctrl.md
Name: muldiv_seq_ctrl

Overview:
Parametrised sequencing controller for the multi-cycle multiply/divide unit in the 5-stage pipeline.
- Accepts mult/div issue strobes from the EX-stage control signals.
- Counts unit latency and raises a pipeline stall request while the operation runs.
- Emits one-shot HI/LO write strobes on completion, and supports cancel (EX flush) and downstream hold.
- Sits beside the main controller; drives the hazard unit (stall_req) and the HI/LO write path.

Parameters:
MUL_LAT, 2, multiply latency in cycles (1..2^CNT_W)
DIV_LAT, 32, divide latency in cycles (1..2^CNT_W)
CNT_W, 6, latency counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
ismultE  in  1  multiply issue request in EX
isdivE  in  1  divide issue request in EX
signedE  in  1  signed-operation flag for the issued op
cancel  in  1  EX flush; aborts an accepted or running op
hold  in  1  downstream stall (stallM); holds DONE
divzero  in  1  divisor-is-zero flag, sampled at accept (used only with optional feature)
stall_req  out  1  stall request to the hazard unit
busy  out  1  state is MUL or DIV
mul_go  out  1  one-cycle start pulse to the multiplier
div_go  out  1  one-cycle start pulse to the divider
signed_o  out  1  latched signed flag
result_valid  out  1  high while state is DONE
hiwrite  out  1  HI write strobe
lowrite  out  1  LO write strobe
cnt  out  CNT_W  remaining-cycle counter, for debug

Behaviour:
- States: IDLE, MUL, DIV, DONE. Reset (rst=0, asynchronous) forces IDLE, cnt=0, signed_o=0, all outputs 0. Reset mid-operation aborts with no HI/LO writes.
- IDLE, accept condition: (ismultE|isdivE) & ~cancel.
  - If isdivE is high it wins over ismultE; simultaneous assertion is treated as a divide.
  - On accept: load cnt with LAT-1, latch signed_o=signedE, pulse mul_go or div_go for the accept cycle only, next state MUL or DIV.
  - cancel in IDLE blocks acceptance.
- stall_req (combinational) = (IDLE & accept) | MUL | DIV. The issuing instruction is frozen in EX from the accept cycle until completion.
- MUL/DIV:
  - cancel=1 -> IDLE next cycle, cnt=0, no strobes.
  - Otherwise, if cnt==0 -> DONE, else cnt decrements by 1.
  - Total cycles in MUL/DIV = LAT. DONE is entered LAT+1 cycles after the accept edge.
  - Issue inputs are ignored while in MUL/DIV.
- DONE:
  - stall_req=0, so the instruction advances. result_valid=1.
  - hiwrite=lowrite=1 for exactly one cycle: the first DONE cycle with hold=0.
  - hold=1 keeps the FSM in DONE with strobes held low; strobes fire once hold drops.
  - After the strobe cycle -> IDLE.
  - Issue inputs in DONE are ignored. Back-to-back mult/div ops therefore incur a minimum one-cycle gap (DONE then IDLE accept).
  - cancel in DONE is ignored; the op has already committed.
- Latency 1 (LAT=1): cnt is loaded with 0; one cycle in MUL/DIV, then DONE.
- cnt never wraps. Decrement occurs only when cnt>0.

Optional Feature:
Macro MULDIV_EARLY_OUT_EN.
- Defined: a divide accepted with divzero=1 goes IDLE -> DONE directly (skips DIV). div_go is not pulsed, stall_req is high only in the accept cycle, and HI/LO strobes follow the normal DONE rules. Software sees HI/LO written with the divider's undefined-result value.
- Undefined: divzero is ignored; divide-by-zero takes the full DIV_LAT cycles.

Test Plan:
- Reset mid-op: MUL_LAT=2. Issue a mult, then drop rst at cycle 1 -> state IDLE immediately; busy, stall_req and strobes all 0; no hiwrite afterwards.
- Basic mult: MUL_LAT=2, ismultE pulse at cycle 0 -> mul_go=1 at cycle 0; stall_req=1 for cycles 0..2; DONE at cycle 3 with hiwrite=lowrite=1 for 1 cycle; IDLE at cycle 4.
- Signed div: DIV_LAT=32, isdivE=1, signedE=1 -> signed_o=1 from cycle 1; stall_req high 33 cycles; single HI/LO strobe at cycle 33.
- Cancel: div accepted, cancel=1 at cycle 10 -> IDLE at cycle 11; hiwrite/lowrite never asserted; a new mult at cycle 11 is accepted.
- Hold/priority: in DONE with hold=1 for 3 cycles -> result_valid=1 and strobes 0 throughout, then exactly one strobe on release. Separately, ismultE=isdivE=1 -> div_go only.
- Early out: with MULDIV_EARLY_OUT_EN, div with divzero=1 -> DONE at cycle 1, strobe at cycle 1, div_go never asserted. Without the macro -> strobe at cycle DIV_LAT+1.
